// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// RV opcode constants, AluControl and AluSrcB encodings, immediate format
// selects and the funct-field to ALU-operation decoder used both at decode
// time (legality) and in the execute states (AluControl drive).
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } imm_fmt_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] op;
  } alu_dec_t;

  // funct7[5] selects SUB/SRA for R-type; for I-type it only matters on
  // right shifts (addi has no subtract form). Any other R-type funct7[5]=1
  // combination has no ALU operation and is reported as not ok.
  function automatic alu_dec_t alu_decode(input logic is_r, input logic f7b5,
                                          input logic [2:0] f3);
    alu_dec_t d;
    d.ok = 1'b1;
    d.op = ALU_ADD;
    case (f3)
      3'b000:  d.op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  d.op = ALU_SLL;
      3'b010:  d.op = ALU_SLT;
      3'b011:  d.op = ALU_SLTU;
      3'b100:  d.op = ALU_XOR;
      3'b101:  d.op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  d.op = ALU_OR;
      default: d.op = ALU_AND;
    endcase
    if (is_r && f7b5 && (f3 != 3'b000) && (f3 != 3'b101)) d.ok = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I, S or B immediate from an instruction
// word and sign-extends it from bit 31 to XLEN. IMM_NONE yields zero.
//   instruction  in   32    raw instruction word
//   fmt          in   2     immediate format select
//   imm          out  XLEN  sign-extended immediate
module imm_gen
  import mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
      IMM_S:   imm = {{(XLEN-12){instruction[31]}}, instruction[31:25],
                      instruction[11:7]};
      IMM_B:   imm = {{(XLEN-13){instruction[31]}}, instruction[31],
                      instruction[7], instruction[30:25], instruction[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RV32I/RV64I-subset core. A Moore FSM
// sequences fetch/decode/execute/memory/writeback, latches decoded fields
// and the sign-extended immediate at the end of DECODE, and drives every
// datapath mux select and write enable.
//   clk, reset          clock, asynchronous active-high reset
//   instruction         IR contents (valid from the cycle after IRWrite)
//   Cond_Chk            ALU zero flag, used only while in BRANCH
//   opcode..rd, Imm     latched instruction fields
//   IorD..AluControl    datapath controls (Moore, from state + latched fields)
//   PCEn                PC enable, includes conditional branch resolution
//   instr_done/illegal  one-cycle completion / illegal-instruction pulses
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instruction,
  input  logic                  Cond_Chk,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       Imm,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  MtoR,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic                  Branch,
  output logic                  PCWrite,
  output logic                  AluSrcA,
  output logic [1:0]            AluSrcB,
  output logic [ALU_CTRL_W-1:0] AluControl,
  output logic                  PCEn,
  output logic                  instr_done,
  output logic                  illegal
);

  state_t          state, state_nx;
  imm_fmt_t        fmt;
  logic [XLEN-1:0] imm_dec;
  alu_dec_t        dec_alu, exe_alu;

  // A 3-bit AluControl cannot express SLT/SLTU.
  function automatic logic fits(input logic [3:0] op);
    return (ALU_CTRL_W >= 4) || (op[3] == 1'b0);
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] ctl(input logic [3:0] op);
    return op[ALU_CTRL_W-1:0];
  endfunction

  always_comb begin
    fmt = IMM_NONE;
    case (instruction[6:0])
      OP_LOAD, OP_ITYPE: fmt = IMM_I;
      OP_STORE:          fmt = IMM_S;
      OP_BRANCH:         fmt = IMM_B;
      default:           fmt = IMM_NONE;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instruction (instruction),
    .fmt         (fmt),
    .imm         (imm_dec)
  );

  // Decode-time view uses the live IR for legality; execute-time view uses
  // the latched fields so AluControl stays a function of registered state.
  assign dec_alu = alu_decode(instruction[6:0] == OP_RTYPE, instruction[30],
                              instruction[14:12]);
  assign exe_alu = alu_decode(state == S_EXEC_R, funct7[5], funct3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode <= '0;
      funct3 <= '0;
      funct7 <= '0;
      rs1    <= '0;
      rs2    <= '0;
      rd     <= '0;
      Imm    <= '0;
    end else if (state == S_DECODE) begin
      opcode <= instruction[6:0];
      funct3 <= instruction[14:12];
      funct7 <= instruction[31:25];
      rs1    <= instruction[19:15];
      rs2    <= instruction[24:20];
      rd     <= instruction[11:7];
      Imm    <= imm_dec;
    end
  end

  always_comb begin
    state_nx   = state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    MtoR       = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    PCWrite    = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = SRCB_RS2;
    AluControl = ctl(ALU_ADD);
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        IRWrite  = 1'b1;
        AluSrcB  = SRCB_FOUR;
        PCWrite  = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        AluSrcB  = SRCB_IMM;
        state_nx = S_ILLEGAL;
        case (instruction[6:0])
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_RTYPE:  if (dec_alu.ok && fits(dec_alu.op)) state_nx = S_EXEC_R;
          OP_ITYPE:  if (dec_alu.ok && fits(dec_alu.op)) state_nx = S_EXEC_I;
          OP_BRANCH: if (instruction[14:13] == 2'b00) state_nx = S_BRANCH;
          default:   state_nx = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        AluSrcA  = 1'b1;
        AluSrcB  = SRCB_IMM;
        state_nx = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD     = 1'b1;
        state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MtoR       = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        AluSrcA    = 1'b1;
        AluSrcB    = (state == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
        AluControl = ctl(exe_alu.op);
        state_nx   = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA    = 1'b1;
        AluControl = ctl(ALU_SUB);
        Branch     = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        instr_done = 1'b1;
        state_nx   = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // funct3[0] distinguishes bne from beq, inverting the taken condition.
  assign PCEn = PCWrite | (Branch & (Cond_Chk ^ funct3[0]));

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import mc_pkg::*;

  // Lane 0: XLEN=32, ALU_CTRL_W=4.  Lane 1: XLEN=64, ALU_CTRL_W=3.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;
  logic [31:0] ir0 = '0, ir1 = '0;
  logic cond0 = 1'b0, cond1 = 1'b0;

  logic [6:0] opcode0, funct70, opcode1, funct71;
  logic [2:0] funct30, funct31;
  logic [4:0] rs10, rs20, rd0, rs11, rs21, rd1;
  logic [31:0] Imm0;
  logic [63:0] Imm1;
  logic IorD0, MemWrite0, MtoR0, IRWrite0, RegWrite0, Branch0, PCWrite0, AluSrcA0, PCEn0, done0, ill0;
  logic IorD1, MemWrite1, MtoR1, IRWrite1, RegWrite1, Branch1, PCWrite1, AluSrcA1, PCEn1, done1, ill1;
  logic [1:0] AluSrcB0, AluSrcB1;
  logic [3:0] AluControl0;
  logic [2:0] AluControl1;

  multicycle_ctrl #(.XLEN(32), .ALU_CTRL_W(4)) dut0 (
    .clk(clk), .reset(reset), .instruction(ir0), .Cond_Chk(cond0),
    .opcode(opcode0), .funct3(funct30), .funct7(funct70), .rs1(rs10), .rs2(rs20), .rd(rd0),
    .Imm(Imm0), .IorD(IorD0), .MemWrite(MemWrite0), .MtoR(MtoR0), .IRWrite(IRWrite0),
    .RegWrite(RegWrite0), .Branch(Branch0), .PCWrite(PCWrite0), .AluSrcA(AluSrcA0),
    .AluSrcB(AluSrcB0), .AluControl(AluControl0), .PCEn(PCEn0), .instr_done(done0),
    .illegal(ill0));

  multicycle_ctrl #(.XLEN(64), .ALU_CTRL_W(3)) dut1 (
    .clk(clk), .reset(reset), .instruction(ir1), .Cond_Chk(cond1),
    .opcode(opcode1), .funct3(funct31), .funct7(funct71), .rs1(rs11), .rs2(rs21), .rd(rd1),
    .Imm(Imm1), .IorD(IorD1), .MemWrite(MemWrite1), .MtoR(MtoR1), .IRWrite(IRWrite1),
    .RegWrite(RegWrite1), .Branch(Branch1), .PCWrite(PCWrite1), .AluSrcA(AluSrcA1),
    .AluSrcB(AluSrcB1), .AluControl(AluControl1), .PCEn(PCEn1), .instr_done(done1),
    .illegal(ill1));

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic iord, memw, mtor, irw, regw, br, pcw, srca;
    logic [1:0]  srcb;
    logic [3:0]  alu;
    logic pcen, done, ill;
  } obs_t;

  obs_t o0, o1;
  always_comb begin
    o0 = '0;
    o0.opcode = opcode0; o0.f3 = funct30; o0.f7 = funct70;
    o0.rs1 = rs10; o0.rs2 = rs20; o0.rd = rd0; o0.imm = {32'b0, Imm0};
    o0.iord = IorD0; o0.memw = MemWrite0; o0.mtor = MtoR0; o0.irw = IRWrite0;
    o0.regw = RegWrite0; o0.br = Branch0; o0.pcw = PCWrite0; o0.srca = AluSrcA0;
    o0.srcb = AluSrcB0; o0.alu = AluControl0; o0.pcen = PCEn0; o0.done = done0; o0.ill = ill0;
  end
  always_comb begin
    o1 = '0;
    o1.opcode = opcode1; o1.f3 = funct31; o1.f7 = funct71;
    o1.rs1 = rs11; o1.rs2 = rs21; o1.rd = rd1; o1.imm = Imm1;
    o1.iord = IorD1; o1.memw = MemWrite1; o1.mtor = MtoR1; o1.irw = IRWrite1;
    o1.regw = RegWrite1; o1.br = Branch1; o1.pcw = PCWrite1; o1.srca = AluSrcA1;
    o1.srcb = AluSrcB1; o1.alu = {1'b0, AluControl1}; o1.pcen = PCEn1; o1.done = done1; o1.ill = ill1;
  end

  typedef struct {
    logic [31:0] w;
    bit          c;
  } prg_t;

  typedef struct {
    int          cycles, nreg, nmem, niord, nmtor, npcen;
    bit          ill;
    logic [3:0]  alu;
    logic [63:0] imm;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
  } rec_t;

  prg_t prog_q0[$], prog_q1[$];
  rec_t exp_q0[$], exp_q1[$];
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: per-instruction behaviour from the ISA rules. Immediates come
  // from arithmetic shifts of the signed word rather than bit concatenation.
  function automatic rec_t model(input logic [31:0] w, input bit c, input int aw, input int xlen);
    rec_t r;
    int base[8];
    int op, sw;
    longint s;
    logic [2:0] f3;
    base = '{0, 5, 8, 9, 4, 6, 3, 2};   // ADD SLL SLT SLTU XOR SRL OR AND
    f3 = w[14:12];
    r.opc = w[6:0]; r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    r.ill = 0; r.nreg = 0; r.nmem = 0; r.niord = 0; r.nmtor = 0; r.npcen = 1;
    r.alu = 4'hF; r.imm = '0; r.cycles = 3;
    sw = int'(w);
    s = longint'(sw);
    case (w[6:0])
      7'b0000011: begin
        r.cycles = 5; r.nreg = 1; r.niord = 1; r.nmtor = 1; r.alu = 4'd0;
        r.imm = s >>> 20;
      end
      7'b0100011: begin
        r.cycles = 4; r.nmem = 1; r.niord = 1; r.alu = 4'd0;
        r.imm = ((s >>> 25) << 5) | longint'(w[11:7]);
      end
      7'b0110011, 7'b0010011: begin
        op = base[f3];
        if (w[6:0] == 7'b0010011) begin
          r.imm = s >>> 20;
          if (f3 == 3'd5 && w[30]) op = 7;
        end else if (w[30]) begin
          op = (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 7 : -1;
        end
        if (op < 0 || op >= (1 << aw)) r.ill = 1;
        else begin r.cycles = 4; r.nreg = 1; r.alu = 4'(op); end
      end
      7'b1100011: begin
        r.imm = ((s >>> 31) << 12) | (longint'(w[7]) << 11) |
                (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        if (f3 <= 3'd1) begin
          r.cycles = 3; r.alu = 4'd1; r.npcen = 1 + int'(c ^ f3[0]);
        end else r.ill = 1;
      end
      default: r.ill = 1;
    endcase
    if (xlen == 32) r.imm = r.imm & 64'hFFFF_FFFF;
    return r;
  endfunction

  task automatic issue(input logic [31:0] w, input bit c);
    prg_t p;
    p.w = w; p.c = c;
    prog_q0.push_back(p); prog_q1.push_back(p);
    exp_q0.push_back(model(w, c, 4, 32));
    exp_q1.push_back(model(w, c, 3, 64));
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = OP_LOAD;
      1: w[6:0] = OP_STORE;
      2: w[6:0] = OP_RTYPE;
      3: w[6:0] = OP_ITYPE;
      4: begin w[6:0] = OP_BRANCH; w[14:13] = 2'b00; end
      5: w[6:0] = OP_BRANCH;
      default: ;
    endcase
    return w;
  endfunction

  // IR model: loads the next program word at the end of FETCH. When the
  // program is exhausted the lane runs filler words that are not scored.
  bit fill0 = 0, fill1 = 0;
  initial forever begin
    @(posedge clk);
    if (IRWrite0) begin
      if (prog_q0.size() > 0) begin
        prg_t p; p = prog_q0.pop_front();
        ir0 <= p.w; cond0 <= p.c; fill0 <= 0;
      end else begin ir0 <= '0; cond0 <= 0; fill0 <= 1; end
    end
    if (IRWrite1) begin
      if (prog_q1.size() > 0) begin
        prg_t p; p = prog_q1.pop_front();
        ir1 <= p.w; cond1 <= p.c; fill1 <= 0;
      end else begin ir1 <= '0; cond1 <= 0; fill1 <= 1; end
    end
  end

  // Monitor: accumulates what each lane does between FETCH and instr_done
  // and scores it against the next queued expectation.
  int cyc[2], nreg[2], nmem[2], niord[2], nmtor[2], npcen[2];
  bit active[2], first[2], last_done[2];
  logic [3:0] alu_seen[2];

  task automatic step(input int l, input obs_t o, input bit fill);
    rec_t e;
    int qs;
    string pf;
    pf = $sformatf("L%0d ", l);
    if (o.irw) begin
      if (!first[l]) chk({pf, "fetch_follows_done"}, 64'(last_done[l]), 64'd1);
      first[l] = 0; active[l] = 1; cyc[l] = 0; nreg[l] = 0; nmem[l] = 0;
      niord[l] = 0; nmtor[l] = 0; npcen[l] = 0; alu_seen[l] = 4'hF;
    end
    last_done[l] = o.done;
    if (active[l]) begin
      cyc[l]++;
      nreg[l] += int'(o.regw); nmem[l] += int'(o.memw); niord[l] += int'(o.iord);
      nmtor[l] += int'(o.mtor); npcen[l] += int'(o.pcen);
      if (o.srca) alu_seen[l] = o.alu;
    end
    if (o.done && active[l]) begin
      active[l] = 0;
      if (!fill) begin
        qs = (l == 0) ? exp_q0.size() : exp_q1.size();
        chk({pf, "exp_available"}, 64'(qs > 0), 64'd1);
        if (qs > 0) begin
          e = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk({pf, "cycles"}, 64'(cyc[l]), 64'(e.cycles));
          chk({pf, "illegal"}, 64'(o.ill), 64'(e.ill));
          chk({pf, "regwrite_cycles"}, 64'(nreg[l]), 64'(e.nreg));
          chk({pf, "memwrite_cycles"}, 64'(nmem[l]), 64'(e.nmem));
          chk({pf, "iord_cycles"}, 64'(niord[l]), 64'(e.niord));
          chk({pf, "mtor_cycles"}, 64'(nmtor[l]), 64'(e.nmtor));
          chk({pf, "pcen_cycles"}, 64'(npcen[l]), 64'(e.npcen));
          chk({pf, "alu_op"}, 64'(alu_seen[l]), 64'(e.alu));
          chk({pf, "imm"}, o.imm, e.imm);
          chk({pf, "opcode"}, 64'(o.opcode), 64'(e.opc));
          chk({pf, "rs1"}, 64'(o.rs1), 64'(e.rs1));
          chk({pf, "rs2"}, 64'(o.rs2), 64'(e.rs2));
          chk({pf, "rd"}, 64'(o.rd), 64'(e.rd));
        end
      end
    end
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin active[l] = 0; first[l] = 1; last_done[l] = 0; end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int l = 0; l < 2; l++) begin active[l] = 0; first[l] = 1; last_done[l] = 0; end
      end else begin
        step(0, o0, fill0);
        step(1, o1, fill1);
      end
    end
  end

  initial begin
    int i;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_zero_L0", 64'(o0 == '0), 64'd1);
    chk("reset_zero_L1", 64'(o1 == '0), 64'd1);

    // Reset asserted in the middle of a load's MEMREAD state.
    issue(32'h00812283, 1'b0);
    #1 reset = 1'b0;
    i = 0;
    while (i < 20 && !(IorD0 && !MemWrite0)) begin @(negedge clk); i++; end
    chk("reach_memread", 64'(IorD0 && !MemWrite0), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_zero_L0", 64'(o0 == '0), 64'd1);
    chk("async_reset_zero_L1", 64'(o1 == '0), 64'd1);
    prog_q0.delete(); prog_q1.delete(); exp_q0.delete(); exp_q1.delete();
    @(negedge clk);
    #1 reset = 1'b0;
    chk("idle_zero_L0", 64'(o0 == '0), 64'd1);

    issue(32'h002081B3, 1'b0);  // add x3,x1,x2
    issue(32'h00812283, 1'b0);  // lw x5,8(x2)
    issue(32'h00512623, 1'b0);  // sw x5,12(x2)
    issue(32'hFE208CE3, 1'b1);  // beq taken
    issue(32'hFE208CE3, 1'b0);  // beq not taken
    issue(32'hFE209CE3, 1'b1);  // bne not taken
    issue(32'hFE209CE3, 1'b0);  // bne taken
    issue(32'hFFFFFFFF, 1'b0);  // illegal
    issue(32'h003120B3, 1'b0);  // slt: illegal only with 3-bit AluControl
    for (int k = 0; k < 150; k++) issue(rand_insn(), 1'($urandom_range(0, 1)));

    @(posedge clk);
    #1;
    chk("first_fetch_irwrite", 64'(IRWrite0), 64'd1);
    chk("first_fetch_pcen", 64'(PCEn0), 64'd1);

    i = 0;
    while (i < 5000 && (exp_q0.size() > 0 || exp_q1.size() > 0)) begin @(negedge clk); i++; end
    chk("scoreboard_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the RV32I/RV64I-subset core; the successor to the single-format decode unit. It sits between the instruction register and the datapath. A state-register FSM sequences fetch, decode, execute, memory and writeback. It latches decoded fields and a sign-extended immediate, and drives every datapath mux and write enable. Added over the previous generation: XLEN-generic immediates, a configurable ALU-control width, load/store/branch/I-type sequencing, bne support and illegal-instruction reporting.

## Interface
- XLEN, 32: datapath width; 32 or 64. Immediate is sign-extended to XLEN.
- ALU_CTRL_W, 4: AluControl width; 3 or 4. With 3, SLT/SLTU are illegal.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instruction  in  32  IR contents; valid from the cycle after IRWrite.
- Cond_Chk  in  1  ALU zero flag (rs1 == rs2).
- opcode / funct3 / funct7  out  7/3/7  latched fields.
- rs1 / rs2 / rd  out  5 each  latched register indices.
- Imm  out  XLEN  latched sign-extended immediate (I, S or B format).
- IorD, MemWrite, MtoR, IRWrite, RegWrite, Branch, PCWrite  out  1 each  datapath controls.
- AluSrcA  out  1  0 = PC, 1 = rs1.
- AluSrcB  out  2  00 = rs2, 01 = constant 4, 10 = Imm.
- AluControl  out  ALU_CTRL_W  ALU operation.
- PCEn  out  1  PC register enable.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.
- illegal  out  1  one-cycle pulse in the ILLEGAL state.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, ILLEGAL.
- Controls are Moore outputs decoded from the state register only. Anything not listed for a state is 0; AluControl defaults to ADD.
- IDLE: all outputs 0. Unconditionally goes to FETCH.
- FETCH: IorD=0, IRWrite=1, AluSrcA=0, AluSrcB=01, ADD, PCWrite=1. Goes to DECODE.
- DECODE: AluSrcA=0, AluSrcB=10, ADD (branch target). Fields and Imm register at the end of this state.
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 with funct3 000/001 -> BRANCH.
  - Any other opcode, any other branch funct3, or an ALU op unencodable at ALU_CTRL_W -> ILLEGAL.
- MEMADR: AluSrcA=1, AluSrcB=10, ADD. Load goes to MEMREAD; store goes to MEMWRITE.
- MEMREAD: IorD=1. Goes to MEMWB.
- MEMWB: RegWrite=1, MtoR=1, instr_done. Goes to FETCH.
- MEMWRITE: IorD=1, MemWrite=1, instr_done. Goes to FETCH.
- EXEC_R: AluSrcA=1, AluSrcB=00, op from {funct7[5], funct3}. Goes to ALUWB.
- EXEC_I: AluSrcA=1, AluSrcB=10, op from funct3; funct7[5] is used only for shifts. Goes to ALUWB.
- ALUWB: RegWrite=1, MtoR=0, instr_done. Goes to FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, SUB, Branch=1, instr_done. Goes to FETCH.
- ILLEGAL: illegal=1, instr_done=1, no writes. Goes to FETCH.
- PCEn = PCWrite | (Branch & (Cond_Chk ^ funct3[0])). This is the only combinational path from an input.
- AluControl encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- Imm formats: I = inst[31:20]; S = {inst[31:25], inst[11:7]}; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}. All sign-extended from bit 31.
- For formats without an immediate, Imm = 0.

## Timing
- Reset, asserted at any time: state = IDLE and all latched fields/Imm = 0. All outputs read 0 within the same cycle.
- First FETCH occurs in the cycle after reset deasserts.
- Cycles per instruction, FETCH through the done state:
  - load 5
  - store 4
  - R-type 4
  - I-type 4
  - branch 3
  - illegal 3
- Latched fields are stable from the cycle after DECODE until the next DECODE ends.
- Cond_Chk is sampled only during BRANCH.

## Structure
- Shared package `mc_pkg` holds:
  - state enum
  - opcode constants
  - AluControl encodings
  - AluSrcB encodings
- Sub-module `imm_gen` (combinational; parameter XLEN; inputs instruction and format select).
- Everything else lives in `multicycle_ctrl`.

## Test plan
- Reset pulse mid-MEMREAD -> outputs 0 immediately. After release: IDLE, then FETCH with IRWrite=1 and PCEn=1.
- 0x002081B3 (add x3,x1,x2):
  - rs1=1, rs2=2, rd=3
  - EXEC_R drives AluControl=0
  - ALUWB drives RegWrite=1, MtoR=0
  - 4 cycles total
- 0x00812283 (lw x5,8(x2)): Imm=8, MEMREAD drives IorD=1, MEMWB drives MtoR=1 and RegWrite=1; 5 cycles total. Then 0x00512623 (sw): Imm=12, MemWrite=1 for exactly one cycle; 4 cycles total.
- 0xFE208CE3 (beq x1,x2,-8): Imm=0xFFFFFFF8. In BRANCH, PCEn=1 when Cond_Chk=1 and PCEn=0 when Cond_Chk=0. The bne variant (funct3=001) gives the inverse.
- 0xFFFFFFFF -> illegal=1 for one cycle and RegWrite/MemWrite never asserted; the next FETCH follows.
- With ALU_CTRL_W=3, 0x003120B3 (slt) -> ILLEGAL. With ALU_CTRL_W=4, the same instruction executes with AluControl=8.
